// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader.
//   ld_state_t     : loader FSM states
//   BYTES_PER_WORD : bytes packed into one instruction word
//   IDX_W          : width of the byte index inside a word
//   LAST_IDX       : byte index of the final byte of a word
package loader_pkg;

  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} ld_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/inst_loader_ctrl_byte_packer.sv
// byte_packer: big-endian byte-to-word packer.
//   i_clk        : clock (posedge)
//   i_rst_n      : synchronous active-low reset
//   i_clear      : drop any partial word and the byte index (wins over i_accept)
//   i_accept     : take i_byte this cycle
//   i_byte       : incoming byte
//   o_idx        : byte index of the next byte within the current word
//   o_word       : last completed word, first byte in the MSBs
//   o_word_valid : 1-cycle pulse, the cycle after the last byte of a word is taken
module byte_packer
  import loader_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [7:0]       i_byte,
  output logic [IDX_W-1:0] o_idx,
  output logic [31:0]      o_word,
  output logic             o_word_valid
);

  localparam int SHIFT_W = (BYTES_PER_WORD - 1) * 8;

  logic [IDX_W-1:0]   r_idx;
  logic               r_word_valid;
  logic [SHIFT_W-1:0] r_shift;
  logic [31:0]        r_word;
  logic               w_last;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx        <= '0;
      r_word_valid <= 1'b0;
    end else if (i_clear) begin
      r_idx        <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_accept) begin
        if (w_last) begin
          r_idx        <= '0;
          r_word_valid <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // Data path carries no reset: the index decides which bytes are meaningful,
  // and the first three bytes of every word overwrite the whole shift register.
  always_ff @(posedge i_clk) begin
    if (i_accept && !i_clear) begin
      if (w_last) begin
        r_word <= {r_shift, i_byte};
      end else begin
        r_shift <= {r_shift[SHIFT_W-9:0], i_byte};
      end
    end
  end

  assign o_idx        = r_idx;
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/inst_loader_ctrl.sv
// inst_loader_ctrl: sequences a program download from the host byte stream
// into instruction memory and holds fetch off while loading.
//   CLK          : clock (posedge)
//   reset        : synchronous active-low reset
//   input_data   : loader byte
//   input_valid  : input_data valid this cycle
//   input_start  : begin a program load (pulse)
//   input_end    : end the program load (pulse)
//   wr_en        : inst memory write strobe, one cycle per word
//   wr_addr      : inst memory word address
//   wr_data      : word written
//   inst_enable  : 1 = fetch may run, 0 = load in progress
//   load_done    : last load finished without errors
//   word_count   : words written in current/last load (saturates at 2**W)
//   overflow_err : sticky, a word completed with memory full
//   partial_err  : sticky, end arrived with 1-3 bytes pending
module inst_loader_ctrl
  import loader_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [7:0]                input_data,
  input  logic                      input_valid,
  input  logic                      input_start,
  input  logic                      input_end,
  output logic                      wr_en,
  output logic [INST_MEM_WIDTH-1:0] wr_addr,
  output logic [31:0]               wr_data,
  output logic                      inst_enable,
  output logic                      load_done,
  output logic [INST_MEM_WIDTH:0]   word_count,
  output logic                      overflow_err,
  output logic                      partial_err
);

  localparam int W = INST_MEM_WIDTH;
  localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};

  ld_state_t        r_state;
  ld_state_t        w_next_state;
  logic             r_wr_en;
  logic [W-1:0]     r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_inst_enable;
  logic             r_load_done;
  logic [W:0]       r_word_count;
  logic             r_overflow_err;
  logic             r_partial_err;

  logic             w_accept;
  logic             w_completes;
  logic             w_pending;
  logic             w_end_evt;
  logic             w_clear;
  logic             w_take;
  logic             w_full;
  logic             w_write;
  logic             w_ovf;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_word;
  logic             w_word_valid;

  // Next-state logic; a start always (re)enters LOAD, taking priority over end.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LD_IDLE: if (input_start) w_next_state = LD_LOAD;
      LD_LOAD: begin
        if (input_start)    w_next_state = LD_LOAD;
        else if (input_end) w_next_state = LD_DONE;
      end
      LD_DONE: if (input_start) w_next_state = LD_LOAD;
      default: w_next_state = LD_IDLE;
    endcase
  end

  // A byte that coincides with start belongs to the aborted load and is dropped.
  assign w_accept    = input_valid && (r_state == LD_LOAD) && !input_start;
  assign w_completes = w_accept && (w_idx == LAST_IDX);
  // Bytes left over once this cycle's byte (if any) has been taken.
  assign w_pending   = w_accept ? (w_idx != LAST_IDX) : (w_idx != '0);
  assign w_end_evt   = (r_state == LD_LOAD) && input_end && !input_start;
  assign w_clear     = input_start || (w_end_evt && w_pending);

  byte_packer u_packer (
    .i_clk        (CLK),
    .i_rst_n      (reset),
    .i_clear      (w_clear),
    .i_accept     (w_accept),
    .i_byte       (input_data),
    .o_idx        (w_idx),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // A completed word is written even after end moved the FSM to DONE;
  // only a restart cancels it.
  assign w_take  = w_word_valid && !input_start;
  assign w_full  = (r_word_count == FULL);
  assign w_write = w_take && !w_full;
  assign w_ovf   = w_take && w_full;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_state        <= LD_IDLE;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_inst_enable  <= 1'b1;
      r_load_done    <= 1'b0;
      r_word_count   <= '0;
      r_overflow_err <= 1'b0;
      r_partial_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr <= r_word_count[W-1:0];
        r_wr_data <= w_word;
      end
      if (input_start) begin
        r_word_count   <= '0;
        r_overflow_err <= 1'b0;
        r_partial_err  <= 1'b0;
        r_load_done    <= 1'b0;
      end else begin
        if (w_write) r_word_count <= r_word_count + 1'b1;
        if (w_ovf) begin
          r_overflow_err <= 1'b1;
          r_load_done    <= 1'b0;
        end
        if (w_end_evt) begin
          if (w_pending) r_partial_err <= 1'b1;
          r_load_done <= !w_pending && !r_overflow_err && !w_ovf;
        end
      end
      // Fetch stays held until the last write of the load has been strobed.
      r_inst_enable <= (w_next_state != LD_LOAD) && !w_completes && !w_write;
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign inst_enable  = r_inst_enable;
  assign load_done    = r_load_done;
  assign word_count   = r_word_count;
  assign overflow_err = r_overflow_err;
  assign partial_err  = r_partial_err;

endmodule
